// File: rtl/uart_host_pkg.sv
// uart_host_pkg
// Shared definitions for the UART host register slave.
// Contents:
//   - word addresses of every register in the host map
//   - default parameter and reset values
//   - state type of the RX read FSM
package uart_host_pkg;

  localparam logic [3:0] ADDR_CTRL      = 4'd0;
  localparam logic [3:0] ADDR_BAUD      = 4'd1;
  localparam logic [3:0] ADDR_OVS       = 4'd2;
  localparam logic [3:0] ADDR_HOLD_TIME = 4'd3;
  localparam logic [3:0] ADDR_HOLD_CNT  = 4'd4;
  localparam logic [3:0] ADDR_TX_DATA   = 4'd5;
  localparam logic [3:0] ADDR_RX_DATA   = 4'd6;
  localparam logic [3:0] ADDR_STATUS    = 4'd7;
  localparam logic [3:0] ADDR_TX_COUNT  = 4'd8;
  localparam logic [3:0] ADDR_RX_COUNT  = 4'd9;
  localparam logic [3:0] ADDR_INT_EN    = 4'd10;
  localparam logic [3:0] ADDR_INT_PEND  = 4'd11;

  localparam int TX_DEPTH_DEF  = 1024;
  localparam int BAUD_RST_DEF  = 868;
  localparam int OVS_RST_DEF   = 173;
  localparam int RX_TMO_DEF    = 4;
  localparam int HOLD_TIME_RST = 4;
  localparam int HOLD_CNT_RST  = 16;

  typedef enum logic [1:0] {
    IDLE,
    POP,
    WAIT
  } rx_state_t;

endpackage

// File: rtl/uart_host_rx_rd.sv
// uart_host_rx_rd
// RX_DATA read sequencer: pops one byte from the RX FIFO and produces the
// completion for the bus.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   start               RX_DATA read accepted this cycle
//   rx_byte_count       current RX FIFO fill level
//   rx_byte_host(_dv)   FIFO read data and its valid strobe
//   rx_byte_host_rd     one-cycle FIFO pop
//   idle                FSM can accept a new bus request
//   ack, empty, data    completion pulse with {empty, data} payload
module uart_host_rx_rd
  import uart_host_pkg::*;
#(
  parameter int RX_TMO = RX_TMO_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [10:0] rx_byte_count,
  input  logic [7:0]  rx_byte_host,
  input  logic        rx_byte_host_dv,
  output logic        rx_byte_host_rd,
  output logic        idle,
  output logic        ack,
  output logic        empty,
  output logic [7:0]  data
);

  rx_state_t  state_q, state_d;
  logic [7:0] tmo_q;
  logic       timeout;
  logic       rd_d;

  // Counts WAIT cycles; the last allowed cycle gives up and reports empty.
  assign timeout = (tmo_q == 8'(RX_TMO - 1));

  // The pop is registered so the FIFO sees it in the first WAIT cycle and
  // its dv lands in the second one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      tmo_q           <= 8'd0;
      rx_byte_host_rd <= 1'b0;
    end else begin
      state_q         <= state_d;
      tmo_q           <= (state_q == WAIT) ? tmo_q + 8'd1 : 8'd0;
      rx_byte_host_rd <= rd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = POP;
      POP:     state_d = (rx_byte_count == 11'd0) ? IDLE : WAIT;
      WAIT:    if (rx_byte_host_dv || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idle  = (state_q == IDLE);
    ack   = 1'b0;
    empty = 1'b0;
    data  = 8'd0;
    rd_d  = 1'b0;
    case (state_q)
      POP: begin
        if (rx_byte_count == 11'd0) begin
          ack   = 1'b1;
          empty = 1'b1;
        end else begin
          rd_d = 1'b1;
        end
      end
      WAIT: begin
        if (rx_byte_host_dv) begin
          ack  = 1'b1;
          data = rx_byte_host;
        end else if (timeout) begin
          ack   = 1'b1;
          empty = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/uart_host_regs.sv
// uart_host_regs
// Word-addressed host register slave in front of uart_top. Holds the line
// configuration, feeds the TX FIFO, pops the RX FIFO and raises irq.
// Build option: UART_HOST_IRQ_LATCH_EN makes INT_PEND sticky rising-edge
// pending flags that drive irq; without it INT_PEND reads 0 and irq is
// the level of int_status & INT_EN.
// Ports:
//   clk, rst                           clock, asynchronous active-low reset
//   bus_addr/wr/rd/wdata               CPU request (one-cycle strobes)
//   bus_rdata, bus_ack                 completion (rdata valid with ack)
//   tx_en, rx_en, baud_clk_cnt, over_sample_clk_cnt,
//   rx_int_holdoff_byte_time_cnt, rx_int_holdoff_byte_cnt  config to uart_top
//   tx_byte_host(_dv)                  TX FIFO write
//   rx_byte_host(_dv), rx_byte_host_rd RX FIFO read
//   tx_byte_count, rx_byte_count       FIFO fill levels
//   int_status                         raw interrupt sources
//   irq                                interrupt to the CPU
module uart_host_regs
  import uart_host_pkg::*;
#(
  parameter int TX_DEPTH = TX_DEPTH_DEF,
  parameter int BAUD_RST = BAUD_RST_DEF,
  parameter int OVS_RST  = OVS_RST_DEF,
  parameter int RX_TMO   = RX_TMO_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  bus_addr,
  input  logic        bus_wr,
  input  logic        bus_rd,
  input  logic [15:0] bus_wdata,
  output logic [15:0] bus_rdata,
  output logic        bus_ack,
  output logic        tx_en,
  output logic        rx_en,
  output logic [12:0] baud_clk_cnt,
  output logic [9:0]  over_sample_clk_cnt,
  output logic [10:0] rx_int_holdoff_byte_time_cnt,
  output logic [10:0] rx_int_holdoff_byte_cnt,
  output logic [7:0]  tx_byte_host,
  output logic        tx_byte_host_dv,
  input  logic [7:0]  rx_byte_host,
  input  logic        rx_byte_host_dv,
  output logic        rx_byte_host_rd,
  input  logic [10:0] tx_byte_count,
  input  logic [10:0] rx_byte_count,
  input  logic [4:0]  int_status,
  output logic        irq
);

  logic [1:0]  ctrl_q;
  logic        tx_ovf_q;
  logic [4:0]  int_en_q;
  logic [4:0]  int_pend;
  logic [15:0] rdata_q;
  logic [15:0] rd_mux;
  logic        reg_ack_q;
  logic        wr_req, rd_req, rx_start;
  logic        rx_idle, rx_ack, rx_empty;
  logic [7:0]  rx_data;
  logic        irq_d;
  logic        unused_wdata;

  assign unused_wdata = ^bus_wdata[15:13];

  // Requests are only taken while no RX read is in flight; a write beats a
  // simultaneous read, which is simply dropped.
  assign wr_req   = bus_wr & rx_idle;
  assign rd_req   = bus_rd & ~bus_wr & rx_idle;
  assign rx_start = rd_req & (bus_addr == ADDR_RX_DATA);

  assign tx_en     = ctrl_q[0];
  assign rx_en     = ctrl_q[1];
  assign bus_ack   = reg_ack_q | rx_ack;
  assign bus_rdata = rx_ack ? {7'd0, rx_empty, rx_data} : rdata_q;

  uart_host_rx_rd #(
    .RX_TMO (RX_TMO)
  ) u_rx_rd (
    .clk             (clk),
    .rst             (rst),
    .start           (rx_start),
    .rx_byte_count   (rx_byte_count),
    .rx_byte_host    (rx_byte_host),
    .rx_byte_host_dv (rx_byte_host_dv),
    .rx_byte_host_rd (rx_byte_host_rd),
    .idle            (rx_idle),
    .ack             (rx_ack),
    .empty           (rx_empty),
    .data            (rx_data)
  );

`ifdef UART_HOST_IRQ_LATCH_EN
  logic [4:0] pend_q, pend_d, status_q, pend_clr;

  // Set wins over a clear landing in the same cycle so no edge is lost.
  assign pend_clr = (wr_req && bus_addr == ADDR_INT_PEND) ? bus_wdata[4:0] : 5'd0;
  assign pend_d   = (pend_q & ~pend_clr) | (int_status & ~status_q);
  assign int_pend = pend_q;
  assign irq_d    = |(pend_d & int_en_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q   <= 5'd0;
      status_q <= 5'd0;
    end else begin
      pend_q   <= pend_d;
      status_q <= int_status;
    end
  end
`else
  assign int_pend = 5'd0;
  assign irq_d    = |(int_status & int_en_q);
`endif

  always_comb begin
    rd_mux = 16'd0;
    case (bus_addr)
      ADDR_CTRL:      rd_mux = {14'd0, ctrl_q};
      ADDR_BAUD:      rd_mux = {3'd0, baud_clk_cnt};
      ADDR_OVS:       rd_mux = {6'd0, over_sample_clk_cnt};
      ADDR_HOLD_TIME: rd_mux = {5'd0, rx_int_holdoff_byte_time_cnt};
      ADDR_HOLD_CNT:  rd_mux = {5'd0, rx_int_holdoff_byte_cnt};
      ADDR_STATUS:    rd_mux = {10'd0, tx_ovf_q, int_status};
      ADDR_TX_COUNT:  rd_mux = {5'd0, tx_byte_count};
      ADDR_RX_COUNT:  rd_mux = {5'd0, rx_byte_count};
      ADDR_INT_EN:    rd_mux = {11'd0, int_en_q};
      ADDR_INT_PEND:  rd_mux = {11'd0, int_pend};
      default:        rd_mux = 16'd0;
    endcase
  end

  // Register file, TX push and non-RX read completion all land one cycle
  // after the strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q                       <= 2'd0;
      baud_clk_cnt                 <= 13'(BAUD_RST);
      over_sample_clk_cnt          <= 10'(OVS_RST);
      rx_int_holdoff_byte_time_cnt <= 11'(HOLD_TIME_RST);
      rx_int_holdoff_byte_cnt      <= 11'(HOLD_CNT_RST);
      int_en_q                     <= 5'd0;
      tx_ovf_q                     <= 1'b0;
      tx_byte_host                 <= 8'd0;
      tx_byte_host_dv              <= 1'b0;
      reg_ack_q                    <= 1'b0;
      rdata_q                      <= 16'd0;
      irq                          <= 1'b0;
    end else begin
      reg_ack_q       <= wr_req | (rd_req & ~rx_start);
      rdata_q         <= (rd_req & ~rx_start) ? rd_mux : 16'd0;
      tx_byte_host_dv <= 1'b0;
      irq             <= irq_d;
      if (wr_req) begin
        case (bus_addr)
          ADDR_CTRL:      ctrl_q <= bus_wdata[1:0];
          ADDR_BAUD:      baud_clk_cnt <= bus_wdata[12:0];
          ADDR_OVS:       over_sample_clk_cnt <= bus_wdata[9:0];
          ADDR_HOLD_TIME: rx_int_holdoff_byte_time_cnt <= bus_wdata[10:0];
          ADDR_HOLD_CNT:  rx_int_holdoff_byte_cnt <= bus_wdata[10:0];
          ADDR_INT_EN:    int_en_q <= bus_wdata[4:0];
          ADDR_STATUS:    if (bus_wdata[5]) tx_ovf_q <= 1'b0;
          ADDR_TX_DATA: begin
            if (int'(tx_byte_count) < TX_DEPTH) begin
              tx_byte_host    <= bus_wdata[7:0];
              tx_byte_host_dv <= 1'b1;
            end else begin
              tx_ovf_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/uart_host_regs.md
# uart_host_regs

Register-mapped host-side bus slave that drives the processor-independent host interface of the UART top level. It holds the baud, oversample and interrupt-holdoff configuration, pushes host writes into the TX FIFO, and pops RX bytes from the RX FIFO through a small read state machine. It also masks the five-bit interrupt status into a single `irq` line. It sits between a simple word-addressed CPU bus and `uart_top`.

## Interface
- `TX_DEPTH`, 1024: TX FIFO capacity in bytes; writes are dropped when `tx_byte_count` ≥ `TX_DEPTH`.
- `BAUD_RST`, 868: reset value of the BAUD register (100 MHz / 115200).
- `OVS_RST`, 173: reset value of the OVS register (`BAUD_RST`/5).
- `RX_TMO`, 4: cycles to wait for `rx_byte_host_dv` before acking an RX read as empty.
- `clk  input  1  clock; all logic is on the rising edge`
- `rst  input  1  asynchronous active-low reset`
- `bus_addr  input  4  word address`
- `bus_wr / bus_rd  input  1  one-cycle request strobes`
- `bus_wdata  input  16  write data`
- `bus_rdata  output  16  read data; valid when bus_ack=1`
- `bus_ack  output  1  one-cycle completion pulse for every accepted request`
- `tx_en, rx_en  output  1  enables to uart_top`
- `baud_clk_cnt  output  13`; `over_sample_clk_cnt  output  10`
- `rx_int_holdoff_byte_time_cnt, rx_int_holdoff_byte_cnt  output  11`
- `tx_byte_host  output  8`; `tx_byte_host_dv  output  1  one-cycle TX FIFO write`
- `rx_byte_host  input  8`; `rx_byte_host_dv  input  1  FIFO valid, one cycle after rd`
- `rx_byte_host_rd  output  1  one-cycle RX FIFO pop`
- `tx_byte_count, rx_byte_count  input  11`; `int_status  input  5  {time_coal, cnt_coal, rx_not_empty, tx_almost_empty, tx_empty}`
- `irq  output  1  level interrupt to the CPU`

## Operation
- Register map (word addresses):
  - 0 CTRL: [0] tx_en, [1] rx_en; resets to 0.
  - 1 BAUD [12:0]: resets to `BAUD_RST`.
  - 2 OVS [9:0]: resets to `OVS_RST`.
  - 3 HOLD_TIME [10:0]: resets to 4.
  - 4 HOLD_CNT [10:0]: resets to 16.
  - 5 TX_DATA: write only; reads return 0.
  - 6 RX_DATA: read only; returns {7'b0, empty, data[7:0]}.
  - 7 STATUS: [4:0] int_status (live), [5] tx_ovf (sticky); writing 1 to bit 5 clears tx_ovf.
  - 8 TX_COUNT; 9 RX_COUNT.
  - 10 INT_EN [4:0]: resets to 0.
  - 11 INT_PEND (see Configuration).
  - Addresses 12–15 read 0; writes to them are ignored but still acked.
- Register widths: write data is truncated to the register width; read data is zero-extended.
- TX_DATA write:
  - If `tx_byte_count` < `TX_DEPTH`: drive `tx_byte_host` = wdata[7:0] and pulse `tx_byte_host_dv` in the cycle after the request.
  - Otherwise: no pulse, and tx_ovf is set.
- RX read FSM:
  - IDLE → POP when an RX_DATA read arrives.
  - POP: if `rx_byte_count`==0, ack with empty=1, data=0, and go to IDLE. Else pulse `rx_byte_host_rd` and go to WAIT.
  - WAIT → IDLE on `rx_byte_host_dv`: ack with data=`rx_byte_host`, empty=0.
  - WAIT → IDLE after `RX_TMO` cycles without dv: ack with empty=1.
- Request conflicts:
  - `bus_wr` and `bus_rd` in the same cycle: the write wins and the read is dropped with no ack.
  - Requests arriving while the FSM is not in IDLE are ignored (no ack). The bus must wait for `bus_ack`.
- `irq` = |(int_status & INT_EN), registered.

## Timing
- All outputs reset to 0, except:
  - `baud_clk_cnt` = `BAUD_RST`
  - `over_sample_clk_cnt` = `OVS_RST`
  - holdoff outputs = 4 and 16
- Register write: the value is visible on its output port, and `bus_ack` pulses, 1 cycle after the strobe.
- Non-RX read: `bus_ack` and `bus_rdata` arrive 1 cycle after the strobe.
- RX_DATA read:
  - Non-empty: ack 3 cycles after the strobe (POP, then WAIT with dv).
  - Empty: ack 1 cycle after the strobe.
  - Timeout: ack at most `RX_TMO`+2 cycles after the strobe.
- Reset asserted mid-read: FSM returns to IDLE with no ack. A pending `rx_byte_host_rd` is not reissued.
- `irq` follows a status or enable change by 1 cycle.

## Configuration
- `UART_HOST_IRQ_LATCH_EN` defined:
  - INT_PEND is implemented as sticky per-bit pending flags, set on the rising edge of each int_status bit.
  - Writing 1 to a bit clears it.
  - `irq` = |(INT_PEND & INT_EN).
- `UART_HOST_IRQ_LATCH_EN` undefined:
  - INT_PEND reads 0 and writes to it are ignored.
  - `irq` is level: |(int_status & INT_EN).

## Structure
- Package `uart_host_pkg`: register address constants (ADDR_CTRL … ADDR_INT_PEND), reset-value constants, and the RX FSM state enum {IDLE, POP, WAIT}.
- One sub-module: `uart_host_rx_rd`, containing the RX read FSM and its timeout counter. It outputs `rx_byte_host_rd`, an ack, and {empty, data}.

## Test plan
- Reset, then read BAUD, OVS, HOLD_TIME, HOLD_CNT → 868, 173, 4, 16, each with an ack 1 cycle after the strobe.
- Write 0x00A5 to TX_DATA with `tx_byte_count`=5 → `tx_byte_host`=0xA5 and a one-cycle dv pulse. With count=1024 → no dv, and STATUS[5]=1. Write 0x20 to STATUS → STATUS[5]=0.
- RX read with `rx_byte_count`=3 and FIFO model returning 0x5C with dv one cycle after rd → `bus_rdata`=0x005C, ack 3 cycles after the strobe. With count=0 → 0x0100 after 1 cycle.
- RX read with FIFO model never asserting dv → `bus_rdata`=0x0100, ack within `RX_TMO`+2 cycles. FSM then accepts a new read.
- INT_EN=0x04 and int_status bit 2 rising → `irq`=1 next cycle. With the macro defined, `irq` stays 1 after the status bit falls until 0x04 is written to INT_PEND.
- Simultaneous `bus_wr`+`bus_rd` to CTRL with wdata=3 → `tx_en`=`rx_en`=1 and exactly one ack. Drop `rst` during WAIT → no ack, FSM in IDLE, outputs at reset values.
